module_bin_bcd: RTL

Sequential binary-to-BCD converter for the display path. Sits directly downstream of the display-priority selector: it takes the selected 16-bit magnitude (`numero_output`) and converts it to five packed BCD digits with the shift-and-add-3 algorithm, one bit per clock. It also produces a leading-zero enable mask for the 7-segment multiplexer. Conversion retriggers whenever the selected value changes.

---
 rtl/module_bin_bcd_pkg.sv | 17 +
 rtl/module_bcd_add3.sv | 14 +
 rtl/module_bin_bcd.sv | 135 +++++++++++++
 3 files changed

// File: rtl/module_bin_bcd_pkg.sv
// Shared display-path types and constants for the binary-to-BCD converter.
`timescale 1ns/1ps
package pkg_display;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int BIN_W_DEF  = 16;
  localparam int DIGITS_DEF = 5;
  localparam int CNT_W      = 5;

  localparam logic [3:0] BCD_ADD = 4'd3;
  localparam logic [3:0] BCD_THR = 4'd5;

endpackage

// File: rtl/module_bcd_add3.sv
// Nibble corrector for shift-and-add-3: digits of 5 or more get +3 before the shift.
`timescale 1ns/1ps
module module_bcd_add3
  import pkg_display::*;
(
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  always_comb begin
    nib_out = (nib_in >= BCD_THR) ? (nib_in + BCD_ADD) : nib_in;
  end

endmodule

// File: rtl/module_bin_bcd.sv
// Sequential binary-to-BCD converter, one bit per clock, with leading-zero digit mask.
// state | meaning
// IDLE  | waiting for bin_in to differ from last converted value
// SHIFT | one correct-and-shift step per cycle, BIN_W cycles total
`timescale 1ns/1ps
module module_bin_bcd
  import pkg_display::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  busy,
  output logic                  done
);

  localparam logic [DIGITS-1:0] EN_RST = DIGITS'(1);

  state_t                state_q, state_d;
  logic [BIN_W-1:0]      last_bin_q, last_bin_d;
  logic [BIN_W-1:0]      bin_sr_q, bin_sr_d;
  logic [4*DIGITS-1:0]   bcd_sr_q, bcd_sr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   bcd_out_q, bcd_out_d;
  logic [DIGITS-1:0]     digit_en_q, digit_en_d;
  logic                  done_q, done_d;

  logic [4*DIGITS-1:0]   bcd_corr;
  logic [4*DIGITS-1:0]   bcd_shift;
  logic [BIN_W-1:0]      bin_shift;
  logic [DIGITS-1:0]     en_mask;
  logic                  any_nz;
  logic                  last_step;
  logic                  start;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    module_bcd_add3 u_add3 (
      .nib_in  (bcd_sr_q[4*g +: 4]),
      .nib_out (bcd_corr[4*g +: 4])
    );
  end

  assign bcd_shift = {bcd_corr[4*DIGITS-2:0], bin_sr_q[BIN_W-1]};
  assign bin_shift = {bin_sr_q[BIN_W-2:0], 1'b0};
  assign last_step = (cnt_q == CNT_W'(BIN_W-1));
  assign start     = (bin_in != last_bin_q);

  // A digit is lit once it or any more significant digit is nonzero.
  always_comb begin
    en_mask = '0;
    any_nz  = 1'b0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      any_nz     = any_nz | (bcd_shift[4*i +: 4] != 4'd0);
      en_mask[i] = any_nz;
    end
    en_mask[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_bin_q <= '0;
      bin_sr_q   <= '0;
      bcd_sr_q   <= '0;
      cnt_q      <= '0;
      bcd_out_q  <= '0;
      digit_en_q <= EN_RST;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_bin_q <= last_bin_d;
      bin_sr_q   <= bin_sr_d;
      bcd_sr_q   <= bcd_sr_d;
      cnt_q      <= cnt_d;
      bcd_out_q  <= bcd_out_d;
      digit_en_q <= digit_en_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_bin_d = last_bin_q;
    bin_sr_d   = bin_sr_q;
    bcd_sr_d   = bcd_sr_q;
    cnt_d      = cnt_q;
    bcd_out_d  = bcd_out_q;
    digit_en_d = digit_en_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_sr_d   = bin_in;
          last_bin_d = bin_in;
          bcd_sr_d   = '0;
          cnt_d      = '0;
        end
      end
      SHIFT: begin
        bin_sr_d = bin_shift;
        bcd_sr_d = bcd_shift;
        cnt_d    = cnt_q + CNT_W'(1);
        // Outputs only move on the final step so the display never shows partial sums.
        if (last_step) begin
          bcd_out_d  = bcd_shift;
          digit_en_d = en_mask;
          done_d     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == SHIFT);
  end

  assign bcd_out  = bcd_out_q;
  assign digit_en = digit_en_q;
  assign done     = done_q;

endmodule
